oled_screen: RTL and testbench

OLED_SCREEN -- requirements
Module: oled_screen

---
 rtl/oled_screen.sv | 175 +++++++++++++++++
 tb/tb_oled_screen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_screen.sv
// oled_screen: SSD1306 SPI driver -- power-up, 25-byte init ROM, framebuffer stream.
// Define OLED_INVERT_EN to send A7 (inverse display) instead of A6 in the init ROM.
module oled_screen #(
  parameter logic [31:0] STARTUP_WAIT = 32'd10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] pixelAddress,
  input  logic [7:0] pixelData,
  output logic       ioSclk,
  output logic       ioSdin,
  output logic       ioCs,
  output logic       ioDc,
  output logic       ioReset
);

  typedef enum logic [2:0] {
    INIT_POWER,
    INIT_RESET,
    INIT_RELEASE,
    LOAD_CMD,
    SEND,
    CHECK_DONE,
    LOAD_DATA,
    WAIT_DATA
  } state_t;

  state_t      state;
  state_t      nextState;
  logic [31:0] waitCnt;
  logic        waitDone;
  logic [4:0]  cmdIdx;
  logic [9:0]  pixelCnt;
  logic [3:0]  sendCnt;
  logic [7:0]  shiftReg;
  logic [7:0]  romByte;
  logic        dataPhase;
  logic        initState;

  function automatic logic [7:0] initRom(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'hD5;
      5'd2:    b = 8'h80;
      5'd3:    b = 8'hA8;
      5'd4:    b = 8'h3F;
      5'd5:    b = 8'hD3;
      5'd6:    b = 8'h00;
      5'd7:    b = 8'h40;
      5'd8:    b = 8'h8D;
      5'd9:    b = 8'h14;
      5'd10:   b = 8'h20;
      5'd11:   b = 8'h00;
      5'd12:   b = 8'hA1;
      5'd13:   b = 8'hC8;
      5'd14:   b = 8'hDA;
      5'd15:   b = 8'h12;
      5'd16:   b = 8'h81;
      5'd17:   b = 8'h7F;
      5'd18:   b = 8'hD9;
      5'd19:   b = 8'hF1;
      5'd20:   b = 8'hDB;
      5'd21:   b = 8'h40;
      5'd22:   b = 8'hA4;
`ifdef OLED_INVERT_EN
      5'd23:   b = 8'hA7;
`else
      5'd23:   b = 8'hA6;
`endif
      5'd24:   b = 8'hAF;
      default: b = 8'hE3;
    endcase
    return b;
  endfunction

  assign romByte   = initRom(cmdIdx);
  assign waitDone  = (waitCnt == STARTUP_WAIT - 32'd1);
  assign initState = (state == INIT_POWER) ||
                     (state == INIT_RESET) ||
                     (state == INIT_RELEASE);
  assign ioSdin    = shiftReg[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_POWER;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      INIT_POWER:   if (waitDone) nextState = INIT_RESET;
      INIT_RESET:   if (waitDone) nextState = INIT_RELEASE;
      INIT_RELEASE: if (waitDone) nextState = LOAD_CMD;
      LOAD_CMD:     nextState = SEND;
      SEND:         if (sendCnt == 4'd15) nextState = CHECK_DONE;
      CHECK_DONE: begin
        if (dataPhase || cmdIdx == 5'd24) nextState = LOAD_DATA;
        else                              nextState = LOAD_CMD;
      end
      LOAD_DATA:    nextState = WAIT_DATA;
      WAIT_DATA:    nextState = SEND;
      default:      nextState = INIT_POWER;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt      <= '0;
      cmdIdx       <= '0;
      pixelCnt     <= '0;
      sendCnt      <= '0;
      shiftReg     <= '0;
      dataPhase    <= 1'b0;
      pixelAddress <= '0;
      ioSclk       <= 1'b0;
      ioCs         <= 1'b1;
      ioDc         <= 1'b0;
      ioReset      <= 1'b1;
    end else begin
      if (initState) begin
        waitCnt <= waitDone ? '0 : waitCnt + 32'd1;
      end
      ioReset <= (nextState != INIT_RESET);
      // chip select drops once and is only raised again by reset
      if (nextState == LOAD_CMD) begin
        ioCs <= 1'b0;
      end
      if (nextState == LOAD_DATA) begin
        pixelAddress <= pixelCnt;
      end
      unique case (state)
        LOAD_CMD: begin
          shiftReg <= romByte;
          ioDc     <= 1'b0;
          sendCnt  <= '0;
          ioSclk   <= 1'b0;
        end
        SEND: begin
          sendCnt <= sendCnt + 4'd1;
          // data shifts on the falling half so it is stable while sclk is high
          if (!sendCnt[0]) begin
            ioSclk <= 1'b1;
          end else begin
            ioSclk   <= 1'b0;
            shiftReg <= {shiftReg[6:0], 1'b0};
          end
        end
        CHECK_DONE: begin
          if (!dataPhase) begin
            if (cmdIdx == 5'd24) begin
              dataPhase <= 1'b1;
              pixelCnt  <= '0;
            end else begin
              cmdIdx <= cmdIdx + 5'd1;
            end
          end
        end
        WAIT_DATA: begin
          shiftReg <= pixelData;
          ioDc     <= 1'b1;
          pixelCnt <= pixelCnt + 10'd1;
          sendCnt  <= '0;
          ioSclk   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_screen.sv
// tb_oled_screen: SPI-decoding scoreboard bench for oled_screen.
// Init ROM bytes, pixel stream, frame wrap, byte period and mid-byte reset.
`timescale 1ns/1ps
module tb_oled_screen;

  localparam logic [31:0] SW = 32'd4;
`ifdef OLED_INVERT_EN
  localparam logic [7:0] DISP_CMD = 8'hA7;
`else
  localparam logic [7:0] DISP_CMD = 8'hA6;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData;
  logic       ioSclk, ioSdin, ioCs, ioDc, ioReset;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] initTab [25];

  logic [7:0] rxByte [$];
  logic       rxDc [$];
  int         rxStart [$];
  logic [7:0] expQ [$];

  logic [7:0] mBits;
  int         mCnt = 0;
  int         mStart = 0;
  logic       prevSclk = 1'b0;
  logic       prevSdin = 1'b0;
  logic       prevDc = 1'b0;
  int         stableErr = 0;
  logic [9:0] prevAddr = '0;
  bit         seen1023 = 1'b0;
  bit         sawWrap = 1'b0;

  oled_screen #(.STARTUP_WAIT(SW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pixelAddress(pixelAddress),
    .pixelData(pixelData),
    .ioSclk(ioSclk),
    .ioSdin(ioSdin),
    .ioCs(ioCs),
    .ioDc(ioDc),
    .ioReset(ioReset)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // registered framebuffer model
  always @(posedge clk) pixelData <= pixelAddress[7:0] ^ 8'h5A;

  always @(negedge clk) begin
    prevAddr <= pixelAddress;
    if (pixelAddress == 10'd1023) seen1023 <= 1'b1;
    if (prevAddr == 10'd1023 && pixelAddress == 10'd0) sawWrap <= 1'b1;
    if (!rst_n) begin
      mCnt     <= 0;
      prevSclk <= 1'b0;
    end else begin
      prevSclk <= ioSclk;
      prevSdin <= ioSdin;
      prevDc   <= ioDc;
      if (ioSclk && prevSclk && (ioSdin !== prevSdin || ioDc !== prevDc))
        stableErr <= stableErr + 1;
      if (ioSclk && !prevSclk) begin
        if (mCnt == 0) mStart <= cyc;
        if (mCnt == 7) begin
          rxByte.push_back({mBits[6:0], ioSdin});
          rxDc.push_back(ioDc);
          rxStart.push_back(mStart);
          mCnt <= 0;
        end else begin
          mBits <= {mBits[6:0], ioSdin};
          mCnt  <= mCnt + 1;
        end
      end
    end
  end

  task automatic popByte(output logic [7:0] b, output logic dc,
                         output int st, output bit ok);
    int n = 0;
    while (rxByte.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (rxByte.size() != 0);
    b = '0;
    dc = 1'b0;
    st = 0;
    if (ok) begin
      b  = rxByte.pop_front();
      dc = rxDc.pop_front();
      st = rxStart.pop_front();
    end
  endtask

  task automatic pushInit();
    for (int i = 0; i < 25; i++) expQ.push_back(initTab[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ioSclk !== 1'b0 || ioSdin !== 1'b0 || ioDc !== 1'b0) begin
      failures++;
      $display("FAIL reset_spi sclk=%b sdin=%b dc=%b want 0 0 0", ioSclk, ioSdin, ioDc);
    end
    checks++;
    if (ioCs !== 1'b1 || ioReset !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctl cs=%b rst=%b want 1 1", ioCs, ioReset);
    end
    checks++;
    if (pixelAddress !== 10'd0) begin
      failures++;
      $display("FAIL reset_addr got=%0d want 0", pixelAddress);
    end
  endtask

  task automatic test_power_up();
    logic [15:0] rv, cv, sv;
    logic s14;
    @(negedge clk);
    pushInit();
    rst_n = 1'b1;
    #1;
    s14 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rv[k] = ioReset;
      cv[k] = ioCs;
      sv[k] = ioSclk;
      if (k == 14) s14 = ioSdin;
      @(posedge clk);
      #1;
    end
    checks++;
    if (rv !== 16'hFF0F) begin
      failures++;
      $display("FAIL pwr_ioReset got=%h want ff0f", rv);
    end
    checks++;
    if (cv !== 16'h0FFF) begin
      failures++;
      $display("FAIL pwr_ioCs got=%h want 0fff", cv);
    end
    checks++;
    if (sv !== 16'h4000) begin
      failures++;
      $display("FAIL pwr_ioSclk got=%h want 4000", sv);
    end
    checks++;
    if (s14 !== 1'b1) begin
      failures++;
      $display("FAIL pwr_first_bit got=%b want 1", s14);
    end
  endtask

  task automatic test_init_bytes();
    logic [7:0] b, e;
    logic dc;
    int st;
    bit ok;
    for (int i = 0; i < 25; i++) begin
      popByte(b, dc, st, ok);
      e = expQ.pop_front();
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL init_timeout byte=%0d no byte seen", i);
        expQ.delete();
        break;
      end
      if (b !== e || dc !== 1'b0) begin
        failures++;
        $display("FAIL init_byte%0d got=%h dc=%b want %h dc=0", i, b, dc, e);
      end
    end
  endtask

  task automatic test_data_stream();
    logic [7:0] b, e, b0, b1024, b2048;
    logic dc;
    int st, prevSt;
    bit ok;
    b0 = '0;
    b1024 = '1;
    b2048 = '1;
    prevSt = 0;
    for (int n = 0; n < 2100; n++) expQ.push_back(8'(n % 256) ^ 8'h5A);
    for (int n = 0; n < 2100; n++) begin
      popByte(b, dc, st, ok);
      e = expQ.pop_front();
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL data_timeout byte=%0d no byte seen", n);
        expQ.delete();
        break;
      end
      if (b !== e || dc !== 1'b1) begin
        failures++;
        $display("FAIL data_byte%0d got=%h dc=%b want %h dc=1", n, b, dc, e);
      end
      if (n > 0) begin
        checks++;
        if (st - prevSt != 19) begin
          failures++;
          $display("FAIL data_period byte=%0d got=%0d want 19", n, st - prevSt);
        end
      end
      prevSt = st;
      if (n == 0) b0 = b;
      if (n == 1024) b1024 = b;
      if (n == 2048) b2048 = b;
    end
    checks++;
    if (b1024 !== b0 || b2048 !== b0 || b0 !== 8'h5A) begin
      failures++;
      $display("FAIL frame_wrap b0=%h b1024=%h b2048=%h want 5a", b0, b1024, b2048);
    end
    checks++;
    if (!seen1023 || !sawWrap) begin
      failures++;
      $display("FAIL addr_wrap seen1023=%b wrap=%b want 1 1", seen1023, sawWrap);
    end
    checks++;
    if (stableErr != 0) begin
      failures++;
      $display("FAIL spi_stable got=%0d changes want 0", stableErr);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b, e;
    logic dc;
    int st, n;
    bit ok;
    n = 0;
    @(negedge clk);
    while (!(mCnt == 3 && ioDc === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL midrst_wait got=timeout want data bit 3");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ioSclk !== 1'b0 || ioSdin !== 1'b0 || ioDc !== 1'b0 ||
        ioCs !== 1'b1 || ioReset !== 1'b1 || pixelAddress !== 10'd0) begin
      failures++;
      $display("FAIL midrst_outputs sclk=%b sdin=%b dc=%b cs=%b rst=%b addr=%0d want 0 0 0 1 1 0",
               ioSclk, ioSdin, ioDc, ioCs, ioReset, pixelAddress);
    end
    repeat (3) @(negedge clk);
    rxByte.delete();
    rxDc.delete();
    rxStart.delete();
    expQ.delete();
    pushInit();
    for (int i = 0; i < 3; i++) expQ.push_back(8'(i) ^ 8'h5A);
    rst_n = 1'b1;
    for (int i = 0; i < 28; i++) begin
      popByte(b, dc, st, ok);
      e = expQ.pop_front();
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL midrst_timeout byte=%0d no byte seen", i);
        break;
      end
      if (b !== e || dc !== (i >= 25)) begin
        failures++;
        $display("FAIL midrst_byte%0d got=%h dc=%b want %h dc=%0d", i, b, dc, e, (i >= 25));
      end
    end
  endtask

  initial begin
    initTab = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                8'h81, 8'h7F, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, DISP_CMD,
                8'hAF};
    test_reset();
    test_power_up();
    test_init_bytes();
    test_data_stream();
    test_reset_mid_byte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
